// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 5..9 data bits, optional odd/even parity, 1 or 2 stop bits.
// Reports parity, framing and line-break errors; rejects start-bit glitches.
//
// state       | meaning
// S_IDLE      | line idle, waiting for a falling edge on rx_s
// S_START     | timing to mid start bit, glitch check
// S_DATA      | sampling data bits, LSB first
// S_PAR       | sampling the parity bit
// S_STOP      | sampling stop bit(s), loading outputs on the last one
// S_CLEANUP   | one-cycle gap after a clean frame
// S_WAIT_IDLE | errored frame; hold off until the line returns high
module uart_rx_param #(
  parameter int FREQ      = 24_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 DATA_serial,
  output logic [DATA_BITS-1:0] DATA_byte,
  output logic                 done_tick,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  localparam int CLKS_PER_BIT = FREQ / BAUD_RATE;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(DATA_BITS) + 1;
  localparam bit PAR_EN       = (PARITY == 1) || (PARITY == 2);
  localparam bit PAR_ODD      = (PARITY == 1);
  localparam int STOP_N       = (STOP_BITS >= 2) ? 2 : 1;

  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = (STOP_N == 2);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PAR       = 3'd3,
    S_STOP      = 3'd4,
    S_CLEANUP   = 3'd5,
    S_WAIT_IDLE = 3'd6
  } state_t;

  state_t               state;
  logic                 sync_1;
  logic                 rx_s;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 stop_idx;
  logic                 fe_r;
  logic                 stop1_low;
  logic                 par_err_r;
  logic                 par_bit;

  logic par_exp;
  logic fe_now;
  logic first_low;
  logic brk_now;

  assign par_exp   = PAR_ODD ? ~(^shift) : (^shift);
  assign fe_now    = fe_r | ~rx_s;
  assign first_low = stop_idx ? stop1_low : ~rx_s;
  // A break is all-zero through the first stop bit, which also forces a framing error.
  assign brk_now   = (shift == '0) && !(PAR_EN && par_bit) && first_low;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= DATA_serial;
      rx_s   <= sync_1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      stop_idx   <= 1'b0;
      fe_r       <= 1'b0;
      stop1_low  <= 1'b0;
      par_err_r  <= 1'b0;
      par_bit    <= 1'b0;
      DATA_byte  <= '0;
      done_tick  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= S_START;
        end

        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (rx_s) begin
              state <= S_IDLE;
            end else begin
              state     <= S_DATA;
              bit_idx   <= '0;
              stop_idx  <= 1'b0;
              fe_r      <= 1'b0;
              stop1_low <= 1'b0;
              par_err_r <= 1'b0;
              par_bit   <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (cnt == CNT_FULL) begin
            cnt   <= '0;
            shift <= {rx_s, shift[DATA_BITS-1:1]};
            if (bit_idx == BIT_LAST) state <= PAR_EN ? S_PAR : S_STOP;
            else                     bit_idx <= bit_idx + BIT_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_PAR: begin
          if (cnt == CNT_FULL) begin
            cnt       <= '0;
            par_bit   <= rx_s;
            par_err_r <= rx_s ^ par_exp;
            state     <= S_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (cnt == CNT_FULL) begin
            cnt <= '0;
            if (stop_idx == LAST_STOP) begin
              DATA_byte  <= shift;
              parity_err <= PAR_EN && par_err_r;
              frame_err  <= fe_now;
              break_det  <= brk_now;
              done_tick  <= 1'b1;
              state      <= fe_now ? S_WAIT_IDLE : S_CLEANUP;
            end else begin
              stop_idx  <= 1'b1;
              fe_r      <= ~rx_s;
              stop1_low <= ~rx_s;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_CLEANUP: begin
          done_tick <= 1'b0;
          state     <= S_IDLE;
        end

        // Held-low line must not re-trigger a frame.
        S_WAIT_IDLE: begin
          done_tick <= 1'b0;
          cnt       <= '0;
          if (rx_s) state <= S_IDLE;
        end

        default: begin
          state     <= S_IDLE;
          cnt       <= '0;
          done_tick <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver: the next generation of the fixed 8N1 receiver used on the LCD control path. It supports 5–9 data bits, optional odd/even parity and 1 or 2 stop bits. It reports parity errors, framing errors and line-break conditions. It rejects start-bit glitches and re-arms only after the line returns to idle. It sits between the board serial input pin and the LCD command decoder, which consumes `DATA_byte` on `done_tick`.

## Interface
- `FREQ`, 24_000_000, system clock frequency in Hz
- `BAUD_RATE`, 9600, line rate in bit/s; `CLKS_PER_BIT = FREQ/BAUD_RATE` (≥ 4), `HALF = CLKS_PER_BIT/2`
- `DATA_BITS`, 8, data bits per frame, legal 5..9
- `PARITY`, 0, 0 = none, 1 = odd, 2 = even
- `STOP_BITS`, 1, legal 1 or 2
- `clk` in 1 — single system clock, rising edge
- `reset` in 1 — asynchronous, active-low reset (asserted when 0)
- `DATA_serial` in 1 — asynchronous serial line, idle high
- `DATA_byte` out DATA_BITS — last received data word, LSB first on the line
- `done_tick` out 1 — one-cycle pulse when a frame completes, including errored frames
- `parity_err` out 1 — parity mismatch in the last frame; forced 0 when `PARITY = 0`
- `frame_err` out 1 — a stop bit was sampled low in the last frame
- `break_det` out 1 — last frame was all-zero: data, parity (if enabled) and first stop bit

## Operation
- `DATA_serial` passes through a 2-flop synchroniser. The FSM uses only the second flop (`rx_s`).
- A single counter, width `$clog2(CLKS_PER_BIT)`, times all bits. It is cleared on each state entry and on each sample.
- A bit counter, width `$clog2(DATA_BITS)+1`, indexes data bits.
- **IDLE:** counter held at 0. If `rx_s == 0`, go to START.
- **START:** sample when the counter reaches `HALF-1`.
  - `rx_s == 1`: glitch; return to IDLE with no outputs changed.
  - Otherwise clear the counter and go to DATA.
- **DATA:** sample every `CLKS_PER_BIT` clocks and shift into the shift register, LSB first.
  - After `DATA_BITS` samples, go to PAR if `PARITY != 0`, else STOP.
- **PAR:** sample 1 bit after `CLKS_PER_BIT`.
  - Expected bit: even parity = XOR of data; odd parity = its inverse.
  - Store the mismatch flag.
- **STOP:** sample `STOP_BITS` bits, each after `CLKS_PER_BIT`. Any low sample sets the internal frame-error flag.
  - On the last stop sample, on the same edge: load `DATA_byte`, `parity_err`, `frame_err` and `break_det`, and set `done_tick`.
  - Go to CLEANUP if no framing error, else to WAIT_IDLE.
- **CLEANUP:** clear `done_tick`; go to IDLE next cycle.
- **WAIT_IDLE:** clear `done_tick`; stay until `rx_s == 1`, then go to IDLE. This prevents a held-low line (break) from producing repeated frames.
- **Output holding:** `DATA_byte` and the three flags hold their values until the next `done_tick`; they are never cleared between frames.
- **Break:** `break_det = 1` implies `frame_err = 1` and `DATA_byte = 0`.
- **Unused encodings:** unused state encodings go to IDLE on the next clock.
- **Unsupported parameters:** `PARITY = 3` behaves as 0 and `STOP_BITS > 2` behaves as 2. Illegal values need no other handling.

## Timing
- **Reset:** while `reset == 0`, all outputs are 0, the synchronisers are 1 (idle), the FSM is in IDLE and the counters are 0. The effect is immediate (async). Deassertion is synchronised by the system-level reset bridge.
- **Reset mid-frame:** the partial frame is discarded with no `done_tick`. After release, reception restarts on the next falling edge.
- **Input latency:** 2 clocks from the pin to `rx_s`.
- **Start sample:** `HALF` clocks after START entry.
- **Later samples:** each one exactly `CLKS_PER_BIT` clocks after the previous.
- **Frame completion:** `done_tick` is high for exactly 1 cycle, starting the cycle after the last stop sample edge. `DATA_byte` and the flags are valid in that same cycle.
- **Frame spacing:** minimum gap between `done_tick` pulses is one frame time. Back-to-back frames with no idle gap must be received; IDLE is re-entered at least `HALF - 2` clocks before the next start edge.
- **Bench tolerance:** ±2 clocks on `done_tick` timing relative to the ideal mid-bit schedule.

## Test plan
All cases use `FREQ = 1_600_000`, `BAUD_RATE = 100_000` (16 clk/bit) unless noted.

1. **8N1:** send 0xA5 then immediately 0x3C, no gap → two `done_tick` pulses, `DATA_byte` = 0xA5 then 0x3C, all flags 0.
2. **`DATA_BITS = 7`, `PARITY = 2`:**
   - Send 0x35 with parity bit 0 → `parity_err = 0`.
   - Resend with parity bit 1 → `done_tick`, `DATA_byte = 0x35`, `parity_err = 1`.
3. **`STOP_BITS = 2`:** send 0x81 with the second stop bit low → `frame_err = 1`. The FSM waits in WAIT_IDLE until the line goes high. A following clean 0x42 gives `DATA_byte = 0x42`, `frame_err = 0`.
4. **Glitch:** line low for 5 clocks, then high → no `done_tick`, FSM back in IDLE, outputs unchanged.
5. **Break:** line low for 20 bit times → exactly one `done_tick` with `break_det = 1`, `frame_err = 1`, `DATA_byte = 0`. No further pulse until the line goes high; a following 0x55 is received correctly.
6. **Reset mid-frame:** assert `reset` during data bit 3 → all outputs 0 immediately and no `done_tick`. After release, a full 0x81 frame gives `DATA_byte = 0x81`.
